// File: rtl/ysyx_22041207_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_22041207_pipe_ctrl                                         |
// | Purpose  : pipeline hazard controller (load-use stall, memory wait,        |
// |            EX redirect flush); optional perf counters via                  |
// |            PIPE_CTRL_PERF_EN                                               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ysyx_22041207_pipe_ctrl #(
  parameter int FLUSH_CYCLES   = 1,
  parameter int LOADUSE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  idex_rwaddr,
  input  logic        idex_writeRD,
  input  logic        idex_memRead,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        pc_load,
  output logic        ifid_bubble,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_flush,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_evt,
  output logic [31:0] perf_ldu_evt,
`endif
  output logic        exmem_bubble
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDUSE   = 2'd1,
    S_MEMWAIT = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam logic [3:0] c_flush_reload = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] c_ldu_reload   = 4'(LOADUSE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt;

  logic w_hazard;
  logic w_do_redir, w_do_hold, w_do_ldu, w_do_flush;

  assign w_hazard = idex_memRead & idex_writeRD & (idex_rwaddr != 5'd0) &
                    ((id_use_rs1 & (id_rs1addr == idex_rwaddr)) |
                     (id_use_rs2 & (id_rs2addr == idex_rwaddr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_do_redir  = 1'b0;
    w_do_hold   = 1'b0;
    w_do_ldu    = 1'b0;
    w_do_flush  = 1'b0;

    case (r_state)
      S_RUN: begin
        if (ex_redirect)   w_do_redir = 1'b1;
        else if (mem_busy) w_do_hold  = 1'b1;
        else if (w_hazard) begin
          w_do_ldu = 1'b1;
          if (LOADUSE_CYCLES > 1) begin
            w_state_nxt = S_LDUSE;
            w_cnt_nxt   = c_ldu_reload;
          end
        end
      end
      S_LDUSE: begin
        if (mem_busy) w_do_hold = 1'b1;
        else begin
          w_do_ldu  = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (mem_busy)                    w_do_hold   = 1'b1;
        else if (r_pend || ex_redirect)  w_do_redir  = 1'b1;
        else                             w_state_nxt = S_RUN;
      end
      S_FLUSH: begin
        if (ex_redirect) w_do_redir = 1'b1;
        else begin
          w_do_flush = 1'b1;
          w_cnt_nxt  = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase

    // The EX stage keeps the redirecting instruction while memory is busy, so remember it.
    if (w_do_hold) begin
      w_state_nxt = S_MEMWAIT;
      w_pend_nxt  = r_pend | ex_redirect;
    end

    if (w_do_redir) begin
      w_pend_nxt = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = c_flush_reload;
      end else begin
        w_state_nxt = S_RUN;
      end
    end
  end

  always_comb begin
    pc_load      = w_do_redir;
    pc_stall     = w_do_hold | w_do_ldu;
    ifid_flush   = w_do_redir | w_do_flush;
    idex_flush   = w_do_redir | w_do_flush | w_do_ldu;
    ifid_bubble  = (w_do_hold | w_do_ldu) & ~ifid_flush;
    idex_bubble  = w_do_hold & ~idex_flush;
    exmem_bubble = w_do_hold;
    if (!rst_n) begin
      pc_load      = 1'b0;
      pc_stall     = 1'b0;
      ifid_bubble  = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic w_ldu_evt;
  assign w_ldu_evt = (r_state == S_RUN) & w_do_ldu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_evt <= 32'd0;
      perf_ldu_evt   <= 32'd0;
    end else begin
      if (pc_stall && (perf_stall_cyc != 32'hFFFF_FFFF)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (pc_load && (perf_flush_evt != 32'hFFFF_FFFF))  perf_flush_evt <= perf_flush_evt + 32'd1;
      if (w_ldu_evt && (perf_ldu_evt != 32'hFFFF_FFFF))  perf_ldu_evt   <= perf_ldu_evt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
